lcd_bus_receiver: RTL

Responder-side model of the HD44780-style character LCD bus (RS/E/D) driven by the team's LCD driver FSM. It synchronizes E, qualifies each E pulse by width, and samples RS/D on the falling edge. Accepted transfers are decoded into character and command events, and the block tracks cursor address and display-on state. It sits on the LCD pins for on-board self-check and serves as the bench responder for driver verification.

---
 rtl/lcd_bus_receiver.sv | 121 ++++++++++++
 1 files changed

// File: rtl/lcd_bus_receiver.sv
// Responder for an HD44780-style RS/E/D bus: qualifies E pulses by width, samples on
// the falling edge, decodes char/command writes and tracks cursor and display-on state.
module lcd_bus_receiver #(
  parameter int MIN_E_HIGH  = 1000,
  parameter int BUSY_CYCLES = 4096
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RS,
  input  logic       E,
  input  logic [7:0] D,
  input  logic       ERR_CLR,
  output logic [7:0] CHAR_OUT,
  output logic       CHAR_VALID,
  output logic [7:0] CMD_OUT,
  output logic       CMD_VALID,
  output logic [4:0] CURSOR,
  output logic       DISPLAY_ON,
  output logic       BUSY,
  output logic       ERR_SHORT_E,
  output logic       ERR_BUSY_WRITE
);

  localparam int          BW    = $clog2(BUSY_CYCLES + 1);
  localparam logic [13:0] W_MAX = '1;

  typedef enum logic [1:0] {WAIT_LOW, IDLE, PULSE} state_t;

  state_t          state;
  logic            e_m, e_s, e_q;
  logic            rs_q;
  logic [7:0]      d_q;
  logic [13:0]     width;
  logic [BW-1:0]   busy_cnt;
  logic            fall;

  assign fall = e_q & ~e_s;

  // Chain presets high so a pulse already in progress at reset release never
  // looks like a fresh rising edge; WAIT_LOW then holds until E is seen low.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      e_m <= 1'b1;
      e_s <= 1'b1;
      e_q <= 1'b1;
    end else begin
      e_m <= E;
      e_s <= e_m;
      e_q <= e_s;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rs_q  <= 1'b0;
      d_q   <= 8'h00;
      width <= '0;
    end else begin
      if (e_s) begin
        rs_q <= RS;
        d_q  <= D;
      end
      if (!e_s)              width <= '0;
      else if (width != W_MAX) width <= width + 14'd1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state          <= WAIT_LOW;
      CHAR_OUT       <= 8'h00;
      CHAR_VALID     <= 1'b0;
      CMD_OUT        <= 8'h00;
      CMD_VALID      <= 1'b0;
      CURSOR         <= 5'd0;
      DISPLAY_ON     <= 1'b0;
      BUSY           <= 1'b0;
      busy_cnt       <= '0;
      ERR_SHORT_E    <= 1'b0;
      ERR_BUSY_WRITE <= 1'b0;
    end else begin
      CHAR_VALID <= 1'b0;
      CMD_VALID  <= 1'b0;
      if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
      else                BUSY     <= 1'b0;
      // Clear first so an error flagged in the same cycle overrides it.
      if (ERR_CLR) begin
        ERR_SHORT_E    <= 1'b0;
        ERR_BUSY_WRITE <= 1'b0;
      end
      case (state)
        WAIT_LOW: if (!e_s) state <= IDLE;
        IDLE:     if (e_s)  state <= PULSE;
        PULSE: if (fall) begin
          state <= IDLE;
          if (32'(width) < MIN_E_HIGH) begin
            ERR_SHORT_E <= 1'b1;
          end else if (BUSY) begin
            ERR_BUSY_WRITE <= 1'b1;
          end else begin
            BUSY     <= 1'b1;
            busy_cnt <= BW'(BUSY_CYCLES - 1);
            if (rs_q) begin
              CHAR_OUT   <= d_q;
              CHAR_VALID <= 1'b1;
              CURSOR     <= CURSOR + 5'd1;
            end else begin
              CMD_OUT   <= d_q;
              CMD_VALID <= 1'b1;
              if (d_q[7])                                CURSOR     <= d_q[4:0];
              else if (d_q == 8'h01 || d_q[7:1] == 7'h01) CURSOR     <= 5'd0;
              else if (d_q[7:3] == 5'b00001)             DISPLAY_ON <= d_q[2];
            end
          end
        end
        default: state <= WAIT_LOW;
      endcase
    end
  end

endmodule
